// File: rtl/vec_vsetvl_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vec_vsetvl_ctrl_pkg
// Shared definitions for the vector configuration-instruction controller:
//   - opcode / funct3 constants of the OP-V configuration group
//   - FSM state enum (IDLE, CALC, WRITE, RESP)
//   - packed layout of the low byte of vtype
//   - configuration-instruction kind and its decoder
// ---------------------------------------------------------------------------
package vec_vsetvl_ctrl_pkg;

    localparam logic [6:0] OPCODE_VEC = 7'h57;
    localparam logic [2:0] FUNCT3_CFG = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Low byte of vtype; everything above bit 7 is reserved and must be zero.
    typedef struct packed {
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef enum logic [1:0] {
        CFG_NONE     = 2'd0,
        CFG_VSETVLI  = 2'd1,
        CFG_VSETIVLI = 2'd2,
        CFG_VSETVL   = 2'd3
    } cfg_kind_t;

    // Classifies a 32-bit instruction word. CFG_NONE means "not a
    // configuration instruction" and is reported as illegal.
    function automatic cfg_kind_t decode_cfg(input logic [31:0] w);
        cfg_kind_t kind;
        kind = CFG_NONE;
        if (w[6:0] == OPCODE_VEC && w[14:12] == FUNCT3_CFG) begin
            if (!w[31]) begin
                kind = CFG_VSETVLI;
            end else if (w[30]) begin
                kind = CFG_VSETIVLI;
            end else if (w[30:25] == 6'd0) begin
                kind = CFG_VSETVL;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/vec_vsetvl_ctrl_vlmax_calc.sv
// ---------------------------------------------------------------------------
// vec_vlmax_calc
// Purely combinational VLMAX / vl calculator.
//   vsew, vlmul : vtype fields
//   avl         : selected application vector length
//   vlmax       : (VLEN >> (3 + vsew)) << vlmul, at XLEN width
//   vl          : min(avl, vlmax), unsigned
//   vtype_ok    : vsew and vlmul are both in the supported range (<= 3)
// Reserved upper vtype bits are checked by the instantiating block.
// ---------------------------------------------------------------------------
module vec_vlmax_calc #(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    input  logic [XLEN-1:0] avl,
    output logic [XLEN-1:0] vlmax,
    output logic [XLEN-1:0] vl,
    output logic            vtype_ok
);

    // Elements per register for each supported SEW (e8..e64); constants.
    logic [XLEN-1:0] base_tbl [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_base
            assign base_tbl[gi] = XLEN'(VLEN >> (3 + gi));
        end
    endgenerate

    always_comb begin
        vtype_ok = !vsew[2] && !vlmul[2];
        // For out-of-range fields only the low two bits index the table; the
        // result is meaningless but vtype_ok already flags it.
        vlmax    = base_tbl[vsew[1:0]] << vlmul[1:0];
        vl       = (avl < vlmax) ? avl : vlmax;
    end

endmodule

// File: rtl/vec_vsetvl_ctrl.sv
// ---------------------------------------------------------------------------
// vec_vsetvl_ctrl
// Sequences vsetvli / vsetivli / vsetvl: accepts one instruction, computes
// VLMAX and the new vl, writes vl/vtype to the vector CSR file with a
// single-cycle csrwr_en pulse, and returns vl for write-back to rd.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   inst_valid / inst_ready  : instruction offer / accept (ready in IDLE only)
//   inst, rs1_data, rs2_data : instruction word, AVL operand, vtype operand
//   cur_vl                   : current vl from the CSR file (keep-vl case)
//   csrwr_en, scalar1/2      : CSR write strobe, new vl, new vtype
//   resp_valid / resp_ready  : response handshake
//   rd_wr_en, rd_addr, rd_data, illegal : write-back info and error flag
//
// Timing: accept at N, CALC at N+1, csrwr_en at N+2, resp_valid from N+3.
// Non-configuration instructions go straight from IDLE to RESP.
// ---------------------------------------------------------------------------
module vec_vsetvl_ctrl
    import vec_vsetvl_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] cur_vl,
    output logic            csrwr_en,
    output logic [XLEN-1:0] scalar1,
    output logic [XLEN-1:0] scalar2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            rd_wr_en,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal
);

    localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg, state_next;

    // Capture registers (loaded at accept)
    cfg_kind_t       kind_reg;
    logic [4:0]      rd_reg;
    logic [4:0]      rs1_idx_reg;   // also the vsetivli uimm
    logic [10:0]     zimm_reg;      // inst[30:20]
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] rs2_reg;
    logic [XLEN-1:0] cur_vl_reg;

    // Result registers (loaded in CALC)
    logic            ok_reg;
    logic [XLEN-1:0] vlmax_reg;
    logic [XLEN-1:0] vl_reg;
    logic [XLEN-1:0] vtype_reg;

    cfg_kind_t       accept_kind;
    logic [XLEN-1:0] vtype_sel;
    logic [XLEN-1:0] avl_sel;
    vtype_t          vt_lo;
    logic            rsvd_zero;
    logic [XLEN-1:0] calc_vlmax;
    logic [XLEN-1:0] calc_vl;
    logic            calc_ok;

    assign accept_kind = decode_cfg(inst[31:0]);

    // -----------------------------------------------------------------------
    // Operand selection from the captured instruction
    // -----------------------------------------------------------------------
    always_comb begin
        vtype_sel = '0;
        case (kind_reg)
            CFG_VSETVLI:  vtype_sel = XLEN'(zimm_reg);
            CFG_VSETIVLI: vtype_sel = XLEN'(zimm_reg[9:0]);
            CFG_VSETVL:   vtype_sel = rs2_reg;
            default:      vtype_sel = '0;
        endcase

        if (kind_reg == CFG_VSETIVLI) begin
            avl_sel = XLEN'(rs1_idx_reg);
        end else if (rs1_idx_reg != 5'd0) begin
            avl_sel = rs1_reg;
        end else if (rd_reg != 5'd0) begin
            avl_sel = '1;           // request VLMAX
        end else begin
            avl_sel = cur_vl_reg;   // keep vl, clamped by the new VLMAX
        end
    end

    assign vt_lo     = vtype_t'(vtype_sel[7:0]);
    assign rsvd_zero = ~|vtype_sel[XLEN-1:8];

    vec_vlmax_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN)
    ) u_calc (
        .vsew     (vt_lo.vsew),
        .vlmul    (vt_lo.vlmul),
        .avl      (avl_sel),
        .vlmax    (calc_vlmax),
        .vl       (calc_vl),
        .vtype_ok (calc_ok)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (inst_valid) begin
                    state_next = (accept_kind == CFG_NONE) ? ST_RESP : ST_CALC;
                end
            end
            ST_CALC:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. Everything is forced low while rst is high so an
    // instruction aborted in WRITE never produces a CSR write.
    always_comb begin
        inst_ready = 1'b0;
        csrwr_en   = 1'b0;
        scalar1    = '0;
        scalar2    = '0;
        resp_valid = 1'b0;
        rd_wr_en   = 1'b0;
        rd_addr    = '0;
        rd_data    = '0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: inst_ready = 1'b1;
                ST_WRITE: begin
                    csrwr_en = 1'b1;
                    scalar1  = ok_reg ? vl_reg : '0;
                    scalar2  = ok_reg ? vtype_reg : VTYPE_VILL;
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    rd_wr_en   = (kind_reg != CFG_NONE) && (rd_reg != 5'd0);
                    rd_addr    = rd_reg;
                    rd_data    = ok_reg ? vl_reg : '0;
                    illegal    = !ok_reg;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Capture and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_reg    <= CFG_NONE;
            rd_reg      <= '0;
            rs1_idx_reg <= '0;
            zimm_reg    <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            cur_vl_reg  <= '0;
            ok_reg      <= 1'b0;
            vlmax_reg   <= '0;
            vl_reg      <= '0;
            vtype_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (inst_valid) begin
                        kind_reg    <= accept_kind;
                        rd_reg      <= inst[11:7];
                        rs1_idx_reg <= inst[19:15];
                        zimm_reg    <= inst[30:20];
                        rs1_reg     <= rs1_data;
                        rs2_reg     <= rs2_data;
                        cur_vl_reg  <= cur_vl;
                        // Cleared so a non-configuration instruction
                        // responds as illegal with rd_data = 0.
                        ok_reg      <= 1'b0;
                    end
                end
                ST_CALC: begin
                    ok_reg    <= calc_ok && rsvd_zero;
                    vlmax_reg <= calc_vlmax;
                    vl_reg    <= calc_vl;
                    vtype_reg <= vtype_sel;
                end
                default: ;
            endcase
        end
    end

    // The committed vl can never exceed the VLMAX it was derived from.
    vl_le_vlmax: assert property (@(posedge clk) disable iff (rst)
        (state_reg == ST_WRITE && ok_reg) |-> (vl_reg <= vlmax_reg));

endmodule

// File: doc/vec_vsetvl_ctrl.md
# vec_vsetvl_ctrl

- Sequences the vector configuration instructions `vsetvli`, `vsetivli` and `vsetvl` for the vector co-processor.
- Accepts one instruction and its scalar operands from the scalar processor, then:
  - decodes the requested vtype;
  - computes VLMAX and the new vl;
  - writes both to the vector CSR register file with a single-cycle `csrwr_en` pulse;
  - returns the new vl for write-back to `rd`.
- Sits between the scalar-processor issue interface and the vector CSR register file.
- Handles one instruction at a time.

## Interface
Parameters:
- `XLEN`, default 32: scalar data width.
- `VLEN`, default 512: vector register length in bits. Must be a power of two, ≥ 64.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `inst_valid`, in, 1: an instruction is offered.
- `inst_ready`, out, 1: controller can accept an instruction.
- `inst`, in, XLEN: the instruction word.
- `rs1_data`, in, XLEN: AVL operand.
- `rs2_data`, in, XLEN: vtype operand (`vsetvl` only).
- `cur_vl`, in, XLEN: current vl, read back from the CSR register file.
- `csrwr_en`, out, 1: CSR write strobe.
- `scalar1`, out, XLEN: new vl.
- `scalar2`, out, XLEN: new vtype.
- `resp_valid`, out, 1: response is available.
- `resp_ready`, in, 1: scalar processor accepts the response.
- `rd_wr_en`, out, 1: `rd` write-back is required.
- `rd_addr`, out, 5: destination register.
- `rd_data`, out, XLEN: new vl.
- `illegal`, out, 1: illegal instruction or illegal vtype.

## Operation
Decode:
- Opcode 0x57 with funct3 = 3'b111 is a configuration instruction.
- `inst[31]` = 0: `vsetvli`, vtype = zero-extended `inst[30:20]`.
- `inst[31:30]` = 2'b11: `vsetivli`, vtype = `inst[29:20]`, AVL = zero-extended `inst[19:15]`.
- `inst[31]` = 1 and `inst[30:25]` = 0: `vsetvl`, vtype = `rs2_data`.
- Any other instruction: `illegal` = 1, no CSR write, `rd_wr_en` = 0.

vtype legality:
- Field layout: `vlmul` = [2:0], `vsew` = [5:3], `vta` = [6], `vma` = [7].
- Legal only if `vlmul` ≤ 3, `vsew` ≤ 3, and bits [XLEN-1:8] are all zero.
- Illegal vtype: `scalar1` = 0, `scalar2` = 1 << (XLEN-1), the CSR write still occurs, `illegal` = 1, `rd_data` = 0.

Arithmetic:
- VLMAX = (VLEN >> (3 + vsew)) << vlmul, computed at XLEN width.
- AVL selection:
  - `vsetivli`: the immediate.
  - rs1 ≠ x0: `rs1_data`.
  - rs1 = x0 and rd ≠ x0: all-ones, giving vl = VLMAX.
  - rs1 = rd = x0: `cur_vl`.
- vl = min(AVL, VLMAX), unsigned compare. The keep-vl case is therefore clamped to the new VLMAX.

FSM states:
- IDLE: `inst_ready` = 1. On `inst_valid`, capture `inst`, `rs1_data`, `rs2_data` and `cur_vl`.
  - Configuration instruction: go to CALC.
  - Non-configuration instruction: go to RESP with `illegal` = 1.
- CALC: register the legality flag, VLMAX and vl. Go to WRITE.
- WRITE: `csrwr_en` = 1 for exactly this cycle, with `scalar1` and `scalar2` valid. Go to RESP.
- RESP: `resp_valid` = 1.
  - `rd_wr_en` = `resp_valid` & (rd ≠ 0) & configuration instruction.
  - `rd_addr`, `rd_data` and `illegal` are held stable until `resp_valid` & `resp_ready`, then go to IDLE.

## Timing
- Reset values: all outputs 0 (`inst_ready` = 0 during the reset cycle); state = IDLE.
- Reset in any state forces IDLE on the next edge. No `csrwr_en` is issued for the aborted instruction.
- Accept at cycle N (`inst_valid` & `inst_ready`). CALC is cycle N+1. `csrwr_en` is high in cycle N+2. `resp_valid` rises at N+3.
- The CSR register file holds the new vl/vtype from cycle N+3.
- Minimum 4 cycles per instruction. The next accept is no earlier than the cycle after the response handshake.
- `inst_ready` = 0 outside IDLE. `inst_valid` in those cycles is ignored.
- `resp_ready` held low keeps the FSM in RESP indefinitely, with outputs stable.
- `resp_ready` may be high before `resp_valid`. The handshake completes in the first cycle `resp_valid` is 1.
- `cur_vl` is sampled only at accept.

## Structure
Shared definitions header holds:
- the opcode and funct3 constants;
- the FSM state enum (IDLE, CALC, WRITE, RESP);
- the `vtype` field struct.

Sub-module `vec_vlmax_calc`:
- Combinational.
- Inputs: `vsew`, `vlmul`, AVL.
- Outputs: `vlmax`, `vl`, `vtype_ok`.
- Parameterised on `XLEN` and `VLEN`.

The top level holds the FSM, the capture registers and the response registers.

## Test plan
With `VLEN` = 512:
1. `vsetvli` rd=x5, rs1=x6, `rs1_data` = 100, vtype = e32/m1 (0x10) → `csrwr_en` at N+2 with `scalar1` = 16, `scalar2` = 0x10; `rd_data` = 16; `rd_wr_en` = 1.
2. `vsetvli` rs1=x6, `rs1_data` = 100, vtype = e8/m8 (0x03) → vl = 100. Then rs1=x0, rd=x7, vtype = e16/m2 (0x09) → vl = 64.
3. rs1 = rd = x0, `cur_vl` = 40, vtype = e64/m1 (0x18), VLMAX 8 → vl = 8, `rd_wr_en` = 0.
4. `vsetivli` uimm = 5, vtype = e64/m1 with vta/vma set (0xD8) → vl = 5, `scalar2` = 0xD8.
5. `vsetvl` with `rs2_data` = 0x05 (vlmul = 5) → `scalar1` = 0, `scalar2` = 0x80000000, `illegal` = 1, `rd_data` = 0. Opcode 0x33 → `illegal` = 1, no `csrwr_en`.
6. `resp_ready` held low for 5 cycles → `resp_valid` and `rd_data` stable throughout, `inst_ready` = 0. Separately, assert `rst` during WRITE → no `csrwr_en`, IDLE next cycle.
